// File: rtl/mult_shift_add_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encodings
// and default sizing.
package mult_shift_add_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 5;

    localparam logic [1:0] MULT_IDLE = 2'd0;
    localparam logic [1:0] MULT_RUN  = 2'd1;
    localparam logic [1:0] MULT_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = MULT_IDLE,
        ST_RUN  = MULT_RUN,
        ST_DONE = MULT_DONE
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_seq_if.sv
// Request/result bundle between the execute stage (master) and the
// multiplier (slave).
interface mult_shift_add_seq_if
    import mult_shift_add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                 iStart;
    logic                 iSigned;
    logic [WIDTH-1:0]     iDato_A;
    logic [WIDTH-1:0]     iDato_B;
    logic                 oBusy;
    logic                 oDone;
    logic [2*WIDTH-1:0]   oResult;

    modport master (
        output iStart, iSigned, iDato_A, iDato_B,
        input  oBusy, oDone, oResult
    );

    modport slave (
        input  iStart, iSigned, iDato_A, iDato_B,
        output oBusy, oDone, oResult
    );
endinterface

// File: rtl/mult_shift_add_seq_ffd.sv
// Enabled D flip-flop bank with synchronous active-high clear.
module FFD_POSEDGE_SYNCRONOUS_RESET #(
    parameter int SIZE = 1
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Enable,
    input  logic [SIZE-1:0] D,
    output logic [SIZE-1:0] Q
);
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Q <= '0;
        end else if (Enable) begin
            Q <= D;
        end
    end
endmodule

// File: rtl/mult_shift_add_seq.sv
// Multi-cycle shift-add multiplier for MUL/SMUL: multiplies operand
// magnitudes over WIDTH iterations and applies the sign at the end.
module mult_shift_add_seq
    import mult_shift_add_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 Clock,
    input  logic                 Reset,
    mult_shift_add_seq_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    mult_state_t       stateReg, stateNext;
    logic [PW-1:0]     accReg, accNext;
    logic [PW-1:0]     mcandReg, mcandNext;
    logic [WIDTH-1:0]  mplierReg, mplierNext;
    logic [CNT_W-1:0]  cntReg, cntNext;
    logic              negReg, negNext;
    logic              busyReg, busyNext;

    logic              accept;
    logic              lastIter;
    logic              inDone;
    logic [WIDTH-1:0]  magA, magB;
    logic [PW-1:0]     product;

    assign accept   = bus.iStart && ((stateReg == ST_IDLE) || (stateReg == ST_DONE));
    assign lastIter = (cntReg == CNT_W'(WIDTH - 1));
    assign inDone   = (stateReg == ST_DONE);

    // The most-negative operand negates to itself, which is already the right
    // unsigned magnitude.
    assign magA = (bus.iSigned && bus.iDato_A[WIDTH-1]) ? -bus.iDato_A : bus.iDato_A;
    assign magB = (bus.iSigned && bus.iDato_B[WIDTH-1]) ? -bus.iDato_B : bus.iDato_B;

    assign product  = negReg ? -accReg : accReg;
    assign bus.oBusy = busyReg;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateReg  <= ST_IDLE;
            accReg    <= '0;
            mcandReg  <= '0;
            mplierReg <= '0;
            cntReg    <= '0;
            negReg    <= 1'b0;
            busyReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            accReg    <= accNext;
            mcandReg  <= mcandNext;
            mplierReg <= mplierNext;
            cntReg    <= cntNext;
            negReg    <= negNext;
            busyReg   <= busyNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        accNext    = accReg;
        mcandNext  = mcandReg;
        mplierNext = mplierReg;
        cntNext    = cntReg;
        negNext    = negReg;
        busyNext   = 1'b0;

        case (stateReg)
            ST_RUN: begin
                if (mplierReg[0]) begin
                    accNext = accReg + mcandReg;
                end
                mcandNext  = mcandReg << 1;
                mplierNext = mplierReg >> 1;
                cntNext    = cntReg + CNT_W'(1);
                busyNext   = !lastIter;
                if (lastIter) begin
                    stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // A start in IDLE or DONE overrides whatever the state would do next.
        if (accept) begin
            stateNext  = ST_RUN;
            accNext    = '0;
            mcandNext  = {{WIDTH{1'b0}}, magA};
            mplierNext = magB;
            cntNext    = '0;
            negNext    = bus.iSigned && (bus.iDato_A[WIDTH-1] ^ bus.iDato_B[WIDTH-1]);
            busyNext   = 1'b1;
        end
    end

    // Signed product is captured while DONE is current; the pulse follows it.
    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(PW)) resultFf (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (inDone),
        .D      (product),
        .Q      (bus.oResult)
    );

    FFD_POSEDGE_SYNCRONOUS_RESET #(.SIZE(1)) doneFf (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (1'b1),
        .D      (inDone),
        .Q      (bus.oDone)
    );
endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Self-checking bench: vector table plus random ops through a scoreboard,
// with hand-written back-to-back, ignored-start and mid-run reset sequences.
module tb_mult_shift_add_seq;
    localparam int W = 16;
    localparam int LAT = 17;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          acceptCyc;
    } sb_t;

    logic clk = 1'b0;
    logic srst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   doneCount = 0;
    sb_t  expQ[$];
    vec_t vecs[14];

    mult_shift_add_seq_if #(.WIDTH(W)) bus ();

    mult_shift_add_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .Clock (clk),
        .Reset (srst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else begin
            $display("[TB] ok %s: %h", name, got);
        end
    endfunction

    // Scoreboard: every oDone pops one expected product and checks latency.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus.oDone === 1'b1) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    check("result", bus.oResult, e.exp);
                    check("latency", 32'(cyc - e.acceptCyc), 32'(LAT));
                end
            end
        end
    end

    task automatic startOp(input logic s, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
        sb_t e;
        bus.iSigned = s;
        bus.iDato_A = a;
        bus.iDato_B = b;
        bus.iStart  = 1'b1;
        @(posedge clk);
        #1;
        bus.iStart  = 1'b0;
        bus.iDato_A = $urandom;
        bus.iDato_B = $urandom;
        bus.iSigned = $urandom_range(0, 1);
        e.exp = exp;
        e.acceptCyc = cyc;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input int target, input string name);
        for (int i = 0; i < 60 && doneCount < target; i++) @(negedge clk);
        if (doneCount < target) check({name, "_timeout"}, 32'(doneCount), 32'(target));
        @(negedge clk);
    endtask

    task automatic runOp(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
        int busyCnt = 0;
        bit seen = 0;
        startOp(s, a, b, exp);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.oBusy === 1'b1) busyCnt++;
            if (bus.oDone === 1'b1) seen = 1;
        end
        check("busy_cycles", 32'(busyCnt), 32'd16);
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] model(logic s, logic [15:0] a, logic [15:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (s) return 32'(sa * sb);
        return {16'd0, a} * {16'd0, b};
    endfunction

    initial begin
        int base;
        logic s;
        logic [15:0] a, b;

        vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[1]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
        vecs[2]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[3]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB};
        vecs[4]  = '{1'b0, 16'h0000, 16'hABCD, 32'h00000000};
        vecs[5]  = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
        vecs[6]  = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};
        vecs[7]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[8]  = '{1'b0, 16'h8000, 16'h0002, 32'h00010000};
        vecs[9]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[10] = '{1'b1, 16'h7FFF, 16'hFFFF, 32'hFFFF8001};
        vecs[11] = '{1'b0, 16'h00FF, 16'h0100, 32'h0000FF00};
        vecs[12] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[13] = '{1'b0, 16'hFFFF, 16'h8000, 32'h7FFF8000};

        srst = 1'b1;
        bus.iStart = 1'b0;
        bus.iSigned = 1'b0;
        bus.iDato_A = '0;
        bus.iDato_B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.oBusy), 32'd0);
        check("reset_done", 32'(bus.oDone), 32'd0);
        check("reset_result", bus.oResult, 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        bus.iStart = 1'b1;
        @(posedge clk);
        #1;
        bus.iStart = 1'b0;
        check("reset_over_start_busy", 32'(bus.oBusy), 32'd0);
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) runOp(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            runOp(s, a, b, model(s, a, b));
        end

        // Back-to-back: second start lands in the DONE state.
        base = doneCount;
        @(negedge clk);
        startOp(1'b0, 16'h0003, 16'h0005, 32'h0000000F);
        for (int i = 0; i < 40 && bus.oBusy === 1'b1; i++) @(negedge clk);
        startOp(1'b0, 16'h1234, 16'h0010, 32'h00012340);
        check("b2b_busy_after_accept", 32'(bus.oBusy), 32'd1);
        check("b2b_first_done", 32'(bus.oDone), 32'd1);
        waitDone(base + 2, "b2b");

        // A start during RUN is ignored.
        base = doneCount;
        startOp(1'b0, 16'h1234, 16'h0056, model(1'b0, 16'h1234, 16'h0056));
        repeat (4) @(negedge clk);
        bus.iStart = 1'b1;
        bus.iDato_A = 16'hFFFF;
        bus.iDato_B = 16'hFFFF;
        @(negedge clk);
        bus.iStart = 1'b0;
        waitDone(base + 1, "ignored_start");
        repeat (25) @(negedge clk);
        check("ignored_single_done", 32'(doneCount - base), 32'd1);

        // Reset mid-run aborts with no oDone.
        base = doneCount;
        startOp(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        repeat (7) @(negedge clk);
        srst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_busy", 32'(bus.oBusy), 32'd0);
        check("midreset_result", bus.oResult, 32'd0);
        expQ.delete();
        @(negedge clk);
        srst = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset_no_done", 32'(doneCount - base), 32'd0);
        check("midreset_result_held", bus.oResult, 32'd0);

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
